// File: rtl/x_ctrl_pkg.sv
// Shared types and helpers for the execute-stage hazard controller.
// The tag entry holds rd at a fixed width so that one packed type fits every REG_ADDR_W up to 8.
package x_ctrl_pkg;

  localparam int FWD_REGFILE = 0;
  localparam int TAG_RD_W    = 8;

  typedef struct packed {
    logic                valid;
    logic [TAG_RD_W-1:0] rd;
    logic                is_load;
  } tag_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } xstate_t;

  function automatic int calc_sel_w(input int fwd_depth);
    return (fwd_depth < 1) ? 1 : $clog2(fwd_depth + 1);
  endfunction

endpackage

// File: rtl/x_fwd_match.sv
// Priority matcher for one X-stage source operand against the in-flight tag pipeline.
// It returns the youngest matching entry and flags a load-use hazard when that load is still too young.
module x_fwd_match
  import x_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W     = 5,
  parameter int FWD_DEPTH      = 2,
  parameter int LOAD_FWD_STAGE = 2,
  parameter int SEL_W          = 2
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  rs_used,
  input  tag_t                  entries [FWD_DEPTH],
  output logic [SEL_W-1:0]      sel,
  output logic                  hazard
);

  logic found;

  // entries[k-1] is pipeline entry k; scanning upward and latching the first hit gives youngest-wins
  always_comb begin
    sel    = SEL_W'(FWD_REGFILE);
    hazard = 1'b0;
    found  = 1'b0;
    if (rs_used && (rs != '0)) begin
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        if (!found && entries[k-1].valid && (entries[k-1].rd == TAG_RD_W'(rs))) begin
          found  = 1'b1;
          sel    = SEL_W'(k);
          hazard = entries[k-1].is_load && (k < LOAD_FWD_STAGE);
        end
      end
    end
  end

endmodule

// File: rtl/x_hazard_ctrl.sv
// Execute-stage hazard controller: tag pipeline, per-operand forwarding selects,
// load-use stall, multi-cycle redirect flush and saturating event counters.
module x_hazard_ctrl
  import x_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W     = 5,
  parameter int NUM_SRC        = 2,
  parameter int FWD_DEPTH      = 2,
  parameter int LOAD_FWD_STAGE = 2,
  parameter int FLUSH_CYCLES   = 1,
  parameter int CNT_W          = 32,
  localparam int SEL_W         = calc_sel_w(FWD_DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          x_valid,
  input  logic [REG_ADDR_W-1:0]         x_rd,
  input  logic                          x_wen,
  input  logic                          x_is_load,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] x_rs,
  input  logic [NUM_SRC-1:0]            x_rs_used,
  input  logic                          x_redirect,
  input  logic                          stall_in,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
  output logic                          load_use_stall,
  output logic                          flush,
  output logic                          advance,
  output logic [CNT_W-1:0]              cnt_stall,
  output logic [CNT_W-1:0]              cnt_flush
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  tag_t               entries [FWD_DEPTH];
  tag_t               new_tag;
  logic [NUM_SRC-1:0] hazard_vec;
  logic               x_valid_eff;
  logic               accept;

  xstate_t            state_q, state_d;
  logic [FCW-1:0]     fcnt_q, fcnt_d;
  logic [CNT_W-1:0]   cnt_stall_q, cnt_flush_q;

  // One matcher per source operand; each owns its own slice of fwd_sel
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    x_fwd_match #(
      .REG_ADDR_W     (REG_ADDR_W),
      .FWD_DEPTH      (FWD_DEPTH),
      .LOAD_FWD_STAGE (LOAD_FWD_STAGE),
      .SEL_W          (SEL_W)
    ) u_match (
      .rs      (x_rs[i*REG_ADDR_W +: REG_ADDR_W]),
      .rs_used (x_rs_used[i]),
      .entries (entries),
      .sel     (fwd_sel[i*SEL_W +: SEL_W]),
      .hazard  (hazard_vec[i])
    );
  end

  // Wrong-path instructions inside the flush window are neither recorded nor allowed to redirect
  always_comb begin
    x_valid_eff    = x_valid && (state_q == IDLE);
    load_use_stall = x_valid_eff && (|hazard_vec);
    advance        = !stall_in && !load_use_stall;
    accept         = x_valid_eff && x_redirect && advance;
    flush          = accept || (state_q == FLUSH);
  end

  always_comb begin
    new_tag.valid   = x_valid_eff && x_wen && (x_rd != '0);
    new_tag.rd      = TAG_RD_W'(x_rd);
    new_tag.is_load = x_is_load;
  end

  // A load-use stall injects a bubble at entry 1 while older writers keep draining
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < FWD_DEPTH; k++) begin
        entries[k] <= '0;
      end
    end else if (!stall_in) begin
      entries[0] <= advance ? new_tag : '0;
      for (int k = 1; k < FWD_DEPTH; k++) begin
        entries[k] <= entries[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // The accept cycle is the first flush cycle, so FLUSH covers the remaining FLUSH_CYCLES-1 unstalled cycles
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: begin
        if (accept && (FLUSH_CYCLES > 1)) begin
          state_d = FLUSH;
          fcnt_d  = FCW'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (!stall_in) begin
          if (fcnt_q <= FCW'(1)) begin
            state_d = IDLE;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q - FCW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        fcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_stall_q <= '0;
      cnt_flush_q <= '0;
    end else begin
      if (load_use_stall && !stall_in && (cnt_stall_q != '1)) begin
        cnt_stall_q <= cnt_stall_q + CNT_W'(1);
      end
      if (accept && (cnt_flush_q != '1)) begin
        cnt_flush_q <= cnt_flush_q + CNT_W'(1);
      end
    end
  end

  assign cnt_stall = cnt_stall_q;
  assign cnt_flush = cnt_flush_q;

endmodule

// File: tb/tb_x_hazard_ctrl.sv
// Directed self-checking bench for x_hazard_ctrl with FLUSH_CYCLES = 3 and otherwise default parameters.
module tb_x_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic        x_valid;
  logic [4:0]  x_rd;
  logic        x_wen;
  logic        x_is_load;
  logic [9:0]  x_rs;
  logic [1:0]  x_rs_used;
  logic        x_redirect;
  logic        stall_in;
  logic [3:0]  fwd_sel;
  logic        load_use_stall;
  logic        flush;
  logic        advance;
  logic [31:0] cnt_stall;
  logic [31:0] cnt_flush;

  int n_compared;
  int n_mismatched;

  x_hazard_ctrl #(
    .REG_ADDR_W     (5),
    .NUM_SRC        (2),
    .FWD_DEPTH      (2),
    .LOAD_FWD_STAGE (2),
    .FLUSH_CYCLES   (3),
    .CNT_W          (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .x_valid        (x_valid),
    .x_rd           (x_rd),
    .x_wen          (x_wen),
    .x_is_load      (x_is_load),
    .x_rs           (x_rs),
    .x_rs_used      (x_rs_used),
    .x_redirect     (x_redirect),
    .stall_in       (stall_in),
    .fwd_sel        (fwd_sel),
    .load_use_stall (load_use_stall),
    .flush          (flush),
    .advance        (advance),
    .cnt_stall      (cnt_stall),
    .cnt_flush      (cnt_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic wen, input logic ld,
                       input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used,
                       input logic redir);
    x_valid    = v;
    x_rd       = rd;
    x_wen      = wen;
    x_is_load  = ld;
    x_rs       = {rs1, rs0};
    x_rs_used  = used;
    x_redirect = redir;
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    stall_in = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0);
    #10;
    n_compared++;
    if (advance !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_advance_stalled got %0b expected 0", advance); end
    stall_in = 1'b0;
    #1;
    n_compared++;
    if (fwd_sel !== 4'h0) begin n_mismatched++; $display("[TB] FAIL reset_fwd_sel got %0h expected 0", fwd_sel); end
    n_compared++;
    if (load_use_stall !== 1'b0 || flush !== 1'b0 || advance !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL reset_ctrl got lus=%0b flush=%0b adv=%0b expected 0 0 1", load_use_stall, flush, advance);
    end
    n_compared++;
    if (cnt_stall !== 32'd0 || cnt_flush !== 32'd0) begin
      n_mismatched++; $display("[TB] FAIL reset_counters got %0d/%0d expected 0/0", cnt_stall, cnt_flush);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 5'd1, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0);
    n_compared++;
    if (fwd_sel !== 4'h0) begin n_mismatched++; $display("[TB] FAIL b2b_first got %0h expected 0", fwd_sel); end
    tick();
    drive(1'b1, 5'd2, 1'b1, 1'b0, 5'd1, 5'd0, 2'b01, 1'b0);
    n_compared++;
    if (fwd_sel !== 4'h1 || load_use_stall !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL b2b_entry1 got sel=%0h lus=%0b expected 1 0", fwd_sel, load_use_stall);
    end
    tick();
    drive(1'b1, 5'd3, 1'b1, 1'b0, 5'd1, 5'd0, 2'b01, 1'b0);
    n_compared++;
    if (fwd_sel !== 4'h2 || load_use_stall !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL b2b_entry2 got sel=%0h lus=%0b expected 2 0", fwd_sel, load_use_stall);
    end
    tick();
  endtask

  task automatic test_load_use();
    drive(1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0);
    n_compared++;
    if (load_use_stall !== 1'b0) begin n_mismatched++; $display("[TB] FAIL lw_issue_lus got %0b expected 0", load_use_stall); end
    tick();
    drive(1'b1, 5'd6, 1'b1, 1'b0, 5'd0, 5'd5, 2'b10, 1'b0);
    n_compared++;
    if (load_use_stall !== 1'b1 || advance !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL lu_stall got lus=%0b adv=%0b expected 1 0", load_use_stall, advance);
    end
    n_compared++;
    if (fwd_sel !== 4'h4) begin n_mismatched++; $display("[TB] FAIL lu_stall_sel got %0h expected 4", fwd_sel); end
    tick();
    n_compared++;
    if (load_use_stall !== 1'b0 || fwd_sel !== 4'h8 || advance !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL lu_release got lus=%0b sel=%0h adv=%0b expected 0 8 1", load_use_stall, fwd_sel, advance);
    end
    n_compared++;
    if (cnt_stall !== 32'd1) begin n_mismatched++; $display("[TB] FAIL lu_cnt_stall got %0d expected 1", cnt_stall); end
    tick();
    n_compared++;
    if (cnt_stall !== 32'd1) begin n_mismatched++; $display("[TB] FAIL lu_cnt_stall_hold got %0d expected 1", cnt_stall); end
  endtask

  task automatic test_x0_youngest();
    drive(1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0);
    tick();
    drive(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0, 2'b11, 1'b0);
    n_compared++;
    if (fwd_sel !== 4'h0) begin n_mismatched++; $display("[TB] FAIL x0_sel got %0h expected 0", fwd_sel); end
    tick();
    drive(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 5'd0, 2'b11, 1'b0);
    n_compared++;
    if (fwd_sel !== 4'h1 || load_use_stall !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL youngest_x3 got sel=%0h lus=%0b expected 1 0", fwd_sel, load_use_stall);
    end
    tick();
  endtask

  task automatic test_flush();
    drive(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b1);
    n_compared++;
    if (flush !== 1'b1 || advance !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL br_accept got flush=%0b adv=%0b expected 1 1", flush, advance);
    end
    tick();
    n_compared++;
    if (cnt_flush !== 32'd1) begin n_mismatched++; $display("[TB] FAIL br_cnt_flush got %0d expected 1", cnt_flush); end
    drive(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 1'b1);
    n_compared++;
    if (flush !== 1'b1) begin n_mismatched++; $display("[TB] FAIL flush_w2 got %0b expected 1", flush); end
    tick();
    stall_in = 1'b1;
    #1;
    n_compared++;
    if (flush !== 1'b1 || advance !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL flush_stalled got flush=%0b adv=%0b expected 1 0", flush, advance);
    end
    tick();
    stall_in = 1'b0;
    #1;
    n_compared++;
    if (flush !== 1'b1) begin n_mismatched++; $display("[TB] FAIL flush_w3 got %0b expected 1", flush); end
    tick();
    drive(1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 5'd0, 2'b01, 1'b0);
    n_compared++;
    if (flush !== 1'b0) begin n_mismatched++; $display("[TB] FAIL flush_end got %0b expected 0", flush); end
    n_compared++;
    if (fwd_sel !== 4'h0) begin n_mismatched++; $display("[TB] FAIL wrongpath_rec got %0h expected 0", fwd_sel); end
    n_compared++;
    if (cnt_flush !== 32'd1) begin n_mismatched++; $display("[TB] FAIL wrongpath_cnt got %0d expected 1", cnt_flush); end
    tick();
  endtask

  task automatic test_redirect_vs_hazard();
    drive(1'b1, 5'd9, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0);
    tick();
    drive(1'b1, 5'd1, 1'b1, 1'b0, 5'd9, 5'd0, 2'b01, 1'b1);
    n_compared++;
    if (load_use_stall !== 1'b1 || flush !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL rvh_stall got lus=%0b flush=%0b expected 1 0", load_use_stall, flush);
    end
    tick();
    n_compared++;
    if (load_use_stall !== 1'b0 || flush !== 1'b1 || fwd_sel !== 4'h2) begin
      n_mismatched++; $display("[TB] FAIL rvh_accept got lus=%0b flush=%0b sel=%0h expected 0 1 2", load_use_stall, flush, fwd_sel);
    end
    tick();
    n_compared++;
    if (cnt_stall !== 32'd2 || cnt_flush !== 32'd2) begin
      n_mismatched++; $display("[TB] FAIL rvh_counters got %0d/%0d expected 2/2", cnt_stall, cnt_flush);
    end
  endtask

  task automatic test_reset_mid_flush();
    drive(1'b1, 5'd0, 1'b0, 1'b0, 5'd1, 5'd0, 2'b01, 1'b0);
    n_compared++;
    if (flush !== 1'b1 || fwd_sel !== 4'h1) begin
      n_mismatched++; $display("[TB] FAIL jal_link got flush=%0b sel=%0h expected 1 1", flush, fwd_sel);
    end
    reset = 1'b1;
    #1;
    n_compared++;
    if (flush !== 1'b0 || load_use_stall !== 1'b0 || fwd_sel !== 4'h0) begin
      n_mismatched++; $display("[TB] FAIL midrst_ctrl got flush=%0b lus=%0b sel=%0h expected 0 0 0", flush, load_use_stall, fwd_sel);
    end
    n_compared++;
    if (cnt_stall !== 32'd0 || cnt_flush !== 32'd0) begin
      n_mismatched++; $display("[TB] FAIL midrst_counters got %0d/%0d expected 0/0", cnt_stall, cnt_flush);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0);
    tick();
    n_compared++;
    if (flush !== 1'b0 || advance !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL postrst got flush=%0b adv=%0b expected 0 1", flush, advance);
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    test_reset();
    test_back_to_back();
    test_load_use();
    test_x0_youngest();
    test_flush();
    test_redirect_vs_hazard();
    test_reset_mid_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
